alu_mdu_seq: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle datapath ALU.
//  - Adds an iterative multiply/divide unit alongside the 1-cycle integer ops.
//  - Registered result with valid/ready flow control, so it can sit between

---
 rtl/alu_mdu_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: handshaked ALU with an iterative multiply/divide unit.
// Single-cycle integer ops return one cycle after accept; MUL/MULHU (and
// DIVU/REMU when ALU_MDU_DIV_EN is defined) take WIDTH shift steps.
// Results come back in issue order on one registered output port.
// Optional feature macro: ALU_MDU_DIV_EN (iterative restoring divider).
// Without it, ops 12/13 are treated as undefined ops.
module alu_mdu_seq #(
   parameter int unsigned WIDTH     = 32,
   parameter logic [31:0] DEBUG_VAL = 32'hBEEF_DEAD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam int unsigned      SHW      = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] DBG      = WIDTH'(DEBUG_VAL);
   localparam logic [SHW-1:0]   LAST_CNT = SHW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_MULH = 4'd11;
`ifdef ALU_MDU_DIV_EN
   localparam logic [3:0] OP_DIVU = 4'd12;
   localparam logic [3:0] OP_REMU = 4'd13;
`endif

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e           state_q, state_d;
   logic             accept;
   logic             is_multi;
   logic             op_is_mul;
   logic             mop_is_mul;
   logic             last_step;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ill;
   logic [SHW-1:0]   cnt_q;
   logic [3:0]       mop_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] fin_res;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             illegal_q;

   assign accept     = in_valid & in_ready;
   assign op_is_mul  = (op[3:1] == OP_MUL[3:1]);
   assign mop_is_mul = (mop_q[3:1] == OP_MUL[3:1]);
   assign last_step  = (cnt_q == LAST_CNT);
   // Even multi-cycle ops (MUL, DIVU) return the low half, odd ones the high half
   assign fin_res    = mop_q[0] ? step_hi : step_lo;

   // Which ops go through the iterative unit in this build
   always_comb begin
      is_multi = (op == OP_MUL) || (op == OP_MULH);
`ifdef ALU_MDU_DIV_EN
      is_multi = is_multi || (op == OP_DIVU) || (op == OP_REMU);
`endif
   end

   // Single-cycle ALU; anything not handled here is undefined -> DEBUG_VAL
   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (op)
         OP_ADD:  alu_res = A + B;
         OP_SUB:  alu_res = A - B;
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_XOR:  alu_res = A ^ B;
         OP_SLL:  alu_res = A << B[SHW-1:0];
         OP_SRL:  alu_res = A >> B[SHW-1:0];
         OP_SRA:  alu_res = WIDTH'($signed(A) >>> B[SHW-1:0]);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
         default: begin
            alu_res = DBG;
            alu_ill = 1'b1;
         end
      endcase
   end

   // One iteration of the shared mul/div datapath: {hi,lo} holds the
   // product (MUL) or {remainder, dividend/quotient} (DIV)
   always_comb begin
      step_hi = hi_q;
      step_lo = lo_q;
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      if (mop_is_mul) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
`ifdef ALU_MDU_DIV_EN
      else begin
         // Restoring divide; B == 0 naturally yields all-ones quotient, rem = A
         if ({hi_q, lo_q[WIDTH-1]} >= {1'b0, opnd_q}) begin
            step_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} - opnd_q;
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // FSM next state; DONE can hand straight over to a newly accepted op
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = is_multi ? StBusy : StDone;
         StBusy: if (last_step) state_d = StDone;
         StDone: begin
            if (accept)         state_d = is_multi ? StBusy : StDone;
            else if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle:  in_ready = 1'b1;
         StBusy:  in_ready = 1'b0;
         StDone: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: in_ready = 1'b0;
      endcase
   end

   // Operand latch, iteration state and registered result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         mop_q     <= '0;
         opnd_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else if (accept) begin
         if (is_multi) begin
            mop_q <= op;
            cnt_q <= '0;
            hi_q  <= '0;
            if (op_is_mul) begin
               opnd_q <= A;
               lo_q   <= B;
            end else begin
               opnd_q <= B;
               lo_q   <= A;
            end
         end else begin
            result_q  <= alu_res;
            zero_q    <= (alu_res == '0);
            illegal_q <= alu_ill;
         end
      end else if (state_q == StBusy) begin
         cnt_q <= cnt_q + 1'b1;
         hi_q  <= step_hi;
         lo_q  <= step_lo;
         if (last_step) begin
            result_q  <= fin_res;
            zero_q    <= (fin_res == '0);
            illegal_q <= 1'b0;
         end
      end
   end

   assign result  = result_q;
   assign zero    = zero_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq (WIDTH = 32). Honours ALU_MDU_DIV_EN
// the same way the design does.
module tb_alu_mdu_seq;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  A, B, result;
   logic [3:0]    op;
   logic          zero, illegal;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_mdu_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   // ---------------- reference model ----------------
   function automatic bit div_en();
`ifdef ALU_MDU_DIV_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit ref_multi(input logic [3:0] o);
      return (o == 4'd10) || (o == 4'd11) || (div_en() && (o == 4'd12 || o == 4'd13));
   endfunction

   function automatic bit ref_ill(input logic [3:0] o);
      return (o >= 4'd14) || (!div_en() && (o == 4'd12 || o == 4'd13));
   endfunction

   function automatic logic [31:0] ref_res(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      int unsigned s;
      p = 64'(a) * 64'(b);
      s = int'(b[4:0]);
      if (ref_ill(o)) return 32'hBEEF_DEAD;
      case (o)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return a << s;
         4'd6:  return a >> s;
         4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd9:  return (a < b) ? 32'd1 : 32'd0;
         4'd10: return p[31:0];
         4'd11: return p[63:32];
         4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd13: return (b == 0) ? a : a % b;
         default: return 32'hBEEF_DEAD;
      endcase
   endfunction

   // Stimulus driver only: issue one op with out_ready=1 and capture its output.
   // Called and returns at posedge+1.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic il,
                        output int lat);
      int guard;
      out_ready = 1'b1;
      op = o; A = a; B = b; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      r = result; z = zero; il = illegal;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op = '0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
      n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", zero); end
      n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [3:0]  ops [12] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd10, 4'd11,
                                4'd12, 4'd13, 4'd12, 4'd13, 4'd14, 4'd15};
      logic [31:0] as  [12] = '{32'd5, 32'h1234, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                                32'd9, 32'd9, 32'd1, 32'd2};
      logic [31:0] bs  [12] = '{32'd7, 32'h1234, 32'd4, 32'd1, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'd1, 32'd2};
`ifdef ALU_MDU_DIV_EN
      logic [31:0] exp_r [12] = '{32'd12, 32'd0, 32'hF800_0000, 32'd1, 32'hFFFF_FFFE,
                                  32'd1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd9,
                                  32'hBEEF_DEAD, 32'hBEEF_DEAD};
      logic        exp_i [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      int          exp_l [12] = '{1, 1, 1, 1, 33, 33, 33, 33, 33, 33, 1, 1};
`else
      logic [31:0] exp_r [12] = '{32'd12, 32'd0, 32'hF800_0000, 32'd1, 32'hFFFF_FFFE,
                                  32'd1, 32'hBEEF_DEAD, 32'hBEEF_DEAD, 32'hBEEF_DEAD,
                                  32'hBEEF_DEAD, 32'hBEEF_DEAD, 32'hBEEF_DEAD};
      logic        exp_i [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
      int          exp_l [12] = '{1, 1, 1, 1, 33, 33, 1, 1, 1, 1, 1, 1};
`endif
      logic [31:0] r;
      logic        z, il;
      int          lat;
      for (int i = 0; i < 12; i++) begin
         issue(ops[i], as[i], bs[i], r, z, il, lat);
         n_checks++; if (r !== exp_r[i]) begin n_fail++; $display("FAIL directed_result[%0d] op=%0d got %h want %h", i, ops[i], r, exp_r[i]); end
         n_checks++; if (z !== (exp_r[i] == 0)) begin n_fail++; $display("FAIL directed_zero[%0d] got %b want %b", i, z, exp_r[i] == 0); end
         n_checks++; if (il !== exp_i[i]) begin n_fail++; $display("FAIL directed_illegal[%0d] got %b want %b", i, il, exp_i[i]); end
         n_checks++; if (lat != exp_l[i]) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, exp_l[i]); end
      end
   endtask

   task automatic test_busy_ready();
      op = 4'd10; A = 32'h1234_5678; B = 32'h9ABC_DEF0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
         n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL busy_handshake cycle %0d got in_ready=%b out_valid=%b want 0/0", i, in_ready, out_valid); end
         @(posedge clk); #1;
      end
      n_checks++; if (out_valid !== 1'b1 || result !== ref_res(4'd10, 32'h1234_5678, 32'h9ABC_DEF0)) begin
         n_fail++; $display("FAIL busy_done got valid=%b result=%h want 1/%h", out_valid, result, ref_res(4'd10, 32'h1234_5678, 32'h9ABC_DEF0)); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      op = 4'd0; A = 32'd1; B = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (out_valid !== 1'b1 || result !== 32'd2 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL hold cycle %0d got valid=%b result=%h in_ready=%b want 1/2/0", i, out_valid, result, in_ready); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1; op = 4'd4; A = 32'h0000_F0F0; B = 32'h0000_0FF0; in_valid = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1 || result !== 32'h0000_FF00) begin
         n_fail++; $display("FAIL back_to_back got valid=%b result=%h want 1/0000ff00", out_valid, result); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL back_to_back_drain got valid=%b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] r;
      logic        z, il;
      int          lat;
      int          stray;
      op = 4'd10; A = 32'hFFFF_FFFF; B = 32'd2; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset got valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      @(posedge clk); #1 rst = 1'b0;
      stray = 0;
      repeat (W + 4) begin
         @(posedge clk); #1;
         if (out_valid) stray++;
      end
      n_checks++; if (stray != 0) begin n_fail++; $display("FAIL aborted_op_output got %0d valid cycles want 0", stray); end
      issue(4'd0, 32'd3, 32'd4, r, z, il, lat);
      n_checks++; if (r !== 32'd7 || lat != 1) begin
         n_fail++; $display("FAIL post_reset_add got result=%h lat=%0d want 7/1", r, lat); end
   endtask

   // Random stream with random back-pressure; results checked in issue order
   task automatic test_random_stream();
      localparam int N = 80;
      logic [31:0] q_res[$];
      logic        q_ill[$];
      int          sent, got, cyc;
      sent = 0; got = 0; cyc = 0;
      while (got < N && cyc < 20000) begin
         in_valid  = (sent < N) && ($urandom_range(3) != 0);
         op        = 4'($urandom_range(15));
         A         = $urandom;
         B         = ($urandom_range(3) == 0) ? 32'($urandom_range(7)) : $urandom;
         out_ready = ($urandom_range(2) != 0);
         #1;
         if (out_valid) begin
            if (q_res.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL stream_unexpected result=%h with nothing outstanding", result);
            end else begin
               n_checks++; if (result !== q_res[0] || illegal !== q_ill[0] || zero !== (q_res[0] == 0)) begin
                  n_fail++; $display("FAIL stream[%0d] got %h ill=%b z=%b want %h ill=%b z=%b", got, result, illegal, zero, q_res[0], q_ill[0], q_res[0] == 0); end
               if (out_ready) begin
                  void'(q_res.pop_front());
                  void'(q_ill.pop_front());
                  got++;
               end
            end
         end
         if (in_valid && in_ready) begin
            q_res.push_back(ref_res(op, A, B));
            q_ill.push_back(ref_ill(op));
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_checks++; if (got != N) begin n_fail++; $display("FAIL stream_timeout got %0d results want %0d", got, N); end
   endtask

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_directed();
      test_busy_ready();
      test_backpressure();
      test_reset_mid_op();
      test_random_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
